// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter FSM: hands one shared resource to one of N requesters
// at a time. A grant is held until the owner releases it (done or request
// drop) or until the hold timeout forces a release. Each grant is followed by
// a one-cycle GAP and an IDLE cycle before the next grant can be issued.
module rr_arbiter_fsm #(
  parameter int OW      = 2,
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [(2**OW)-1:0]  req,
  input  logic [(2**OW)-1:0]  done,
  output logic [(2**OW)-1:0]  gnt,
  output logic [OW-1:0]       owner,
  output logic                busy,
  output logic                timeout,
  output logic [1:0]          SP,
  output logic [1:0]          SF
);

  localparam int N    = 2**OW;
  // Hold counter only needs to reach TIMEOUT-1; keep one bit when disabled.
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    GAP  = 2'b10
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [OW-1:0]   ptr_reg;
  logic [OW-1:0]   owner_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    gnt_reg;
  logic            busy_reg;
  logic            timeout_reg;

  logic [N-1:0]    rot_req;
  logic [OW-1:0]   pick;
  logic            pick_valid;
  logic            release_owner;
  logic            hold_expired;

  // Rotate the request vector so that bit 0 corresponds to the pointer;
  // the OW-bit index sum wraps modulo N for free.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr_reg + OW'(gi)];
    end
  endgenerate

  // First requester at or after the pointer wins (lowest rotated index).
  always_comb begin
    pick       = '0;
    pick_valid = |rot_req;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        pick = ptr_reg + OW'(i);
      end
    end
  end

  // Only the owner's done/req matter; a voluntary release beats the timeout.
  assign release_owner = done[owner_reg] | ~req[owner_reg];
  assign hold_expired  = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  // Next-state logic, also exported as SF.
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = pick_valid ? BUSY : IDLE;
      BUSY:    state_next = (release_owner || hold_expired) ? GAP : BUSY;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered grant/owner/busy/timeout and pointer/counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      owner_reg   <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            gnt_reg   <= N'(1) << pick;
            owner_reg <= pick;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end else begin
            gnt_reg  <= '0;
            busy_reg <= 1'b0;
          end
        end
        BUSY: begin
          if (state_next == GAP) begin
            // Pointer advances past the owner as GAP begins, so the
            // following IDLE cycle already scans from owner+1.
            gnt_reg     <= '0;
            busy_reg    <= 1'b0;
            ptr_reg     <= owner_reg + 1'b1;
            timeout_reg <= ~release_owner;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        GAP: begin
          gnt_reg  <= '0;
          busy_reg <= 1'b0;
        end
        default: begin
          gnt_reg  <= '0;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_reg;
  assign owner   = owner_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;
  assign SP      = state_reg;
  assign SF      = state_next;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Bench for rr_arbiter_fsm: directed scenarios with literal expectations
// plus a cycle-level behavioural model compared on every negative edge.
module tb_rr_arbiter_fsm;

  localparam int OW      = 2;
  localparam int N       = 4;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  gnt;
  logic [OW-1:0] owner;
  logic          busy;
  logic          timeout;
  logic [1:0]    SP;
  logic [1:0]    SF;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: phase 0=idle, 1=granted, 2=gap (the encoding SP must show).
  int       m_state   = 0;
  int       m_owner   = 0;
  int       m_ptr     = 0;
  int       m_held    = 0;   // grant cycles so far, including the current one
  int       m_gnt     = 0;
  int       m_busy    = 0;
  int       m_timeout = 0;

  rr_arbiter_fsm #(.OW(OW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .gnt(gnt),
    .owner(owner), .busy(busy), .timeout(timeout), .SP(SP), .SF(SF)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Where the arbiter must be headed given the present phase and inputs.
  function automatic int exp_next(input int st, input logic [N-1:0] r,
                                  input logic [N-1:0] d, input int own, input int held);
    if (st == 0) return (r != 0) ? 1 : 0;
    if (st == 1) begin
      if (d[own] || !r[own]) return 2;
      if (TIMEOUT != 0 && held >= TIMEOUT) return 2;
      return 1;
    end
    return 0;
  endfunction

  // Advance the model on each rising edge using the inputs seen there.
  always @(posedge clk) begin
    int nxt;
    int pick;
    if (reset) begin
      m_state = 0; m_owner = 0; m_ptr = 0; m_held = 0;
      m_gnt = 0; m_busy = 0; m_timeout = 0;
    end else begin
      nxt = exp_next(m_state, req, done, m_owner, m_held);
      m_timeout = 0;
      if (m_state == 0) begin
        if (nxt == 1) begin
          pick = -1;
          for (int k = 0; k < N; k++)
            if (pick < 0 && req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
          m_owner = pick; m_gnt = 1 << pick; m_busy = 1; m_held = 1;
        end else begin
          m_gnt = 0; m_busy = 0;
        end
      end else if (m_state == 1) begin
        if (nxt == 2) begin
          m_timeout = (done[m_owner] || !req[m_owner]) ? 0 : 1;
          m_gnt = 0; m_busy = 0;
          m_ptr = (m_owner + 1) % N;
        end else begin
          m_held++;
        end
      end else begin
        m_gnt = 0; m_busy = 0;
      end
      m_state = nxt;
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("sp", 32'(SP), 32'(m_state));
      check("sf", 32'(SF), 32'(exp_next(m_state, req, done, m_owner, m_held)));
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("owner", 32'(owner), 32'(m_owner));
      check("busy", 32'(busy), 32'(m_busy));
      check("timeout", 32'(timeout), 32'(m_timeout));
      check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      if (m_state == 1 && m_held == 1)
        $display("grant ch=%0d gnt=%b t=%0t", m_owner, gnt, $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_rr [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1; req = 4'b1111; done = 4'b0000;

    // 1: reset with all requests high
    tick();
    cmp_en = 1'b1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sp", 32'(SP), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;
    tick();
    check("rst_ptr0_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick(); tick(); tick();

    // 2: single request on channel 2
    req = 4'b0100;
    tick();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_owner", 32'(owner), 32'h2);
    check("single_sp", 32'(SP), 32'h1);
    done = 4'b0100;
    tick();
    check("single_gap_sp", 32'(SP), 32'h2);
    check("single_gap_gnt", 32'(gnt), 32'h0);
    done = 4'b0000;
    tick();
    check("single_idle_sp", 32'(SP), 32'h0);
    req = 4'b1111;
    tick();
    check("single_ptr3", 32'(gnt), 32'h8);

    // 3: round robin with all requesters active, release after 2 cycles
    for (int k = 0; k < 5; k++) begin
      tick();
      done = gnt;
      tick();
      done = 4'b0000;
      tick();
      tick();
      check("rr_owner", 32'(owner), 32'(exp_rr[k]));
    end

    // 4: timeout on channel 1
    req = 4'b0000;
    tick(); tick();
    req = 4'b0010;
    tick();
    check("to_gnt_first", 32'(gnt), 32'h2);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to_gnt_hold", 32'(gnt), 32'h2);
    end
    tick();
    check("to_gnt_drop", 32'(gnt), 32'h0);
    check("to_pulse", 32'(timeout), 32'h1);
    check("to_gap_sp", 32'(SP), 32'h2);
    req = 4'b0011;
    tick();
    check("to_pulse_end", 32'(timeout), 32'h0);
    check("to_idle_sp", 32'(SP), 32'h0);
    tick();
    check("to_wrap_ch0", 32'(gnt), 32'h1);

    // 5: non-owner done ignored; done wins over timeout; reset during BUSY
    done = 4'b0010;
    tick();
    check("nonowner_done", 32'(gnt), 32'h1);
    for (int i = 0; i < 6; i++) tick();
    done = 4'b0001;
    tick();
    check("done_vs_to_pulse", 32'(timeout), 32'h0);
    check("done_vs_to_sp", 32'(SP), 32'h2);
    done = 4'b0000;
    tick();
    tick();
    check("after_ch0_gnt", 32'(gnt), 32'h2);
    reset = 1'b1;
    tick();
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_sp", 32'(SP), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    req = 4'b0000;
    tick();

    // Mixed traffic, checked by the per-cycle model comparison.
    for (int c = 0; c < 400; c++) begin
      req  = 4'($urandom);
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if (c % 50 == 49) req = 4'b1111;
      tick();
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
